// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: opcodes, ALU pipeline depth and the
// issue tag carried alongside each operation while it is inside the ALU.
package alu_pkg;

    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_INC  = 2'b10;
    localparam logic [1:0] ALU_OP_NONE = 2'b11;

    localparam int ALU_LATENCY = 2;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: the search starts at ptr_i and the first active request wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Walk the candidates in priority order; only the first hit is kept
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_o = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand_s        = IDX_W'((int'(ptr_i) + i) % N);
            hit_s         = en_i & ~found_o & req_i[cand_s];
            gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
            idx_o         = hit_s ? cand_s : idx_o;
            found_o       = found_o | hit_s;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one pipelined ALU among NUM_REQ requesters: round-robin issue, a tag pipe that tracks
// which requester owns each in-flight operation, and routing of the returning result.
module alu_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SEL_WIDTH   = 2,
    parameter int ALU_LATENCY = alu_pkg::ALU_LATENCY
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data2_i,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]         req_sel_i,
    output logic                                 alu_valid_o,
    output logic [DATA_WIDTH-1:0]                alu_data1_o,
    output logic [DATA_WIDTH-1:0]                alu_data2_o,
    output logic [SEL_WIDTH-1:0]                 alu_sel_o,
    input  logic                                 alu_valid_i,
    input  logic [2*DATA_WIDTH-1:0]              alu_data_i,
    output logic [NUM_REQ-1:0]                   resp_valid_o,
    output logic [2*DATA_WIDTH-1:0]              resp_data_o,
    output logic [$clog2(ALU_LATENCY+1)-1:0]     inflight_o,
    output logic                                 err_o
);
    import alu_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;
    tag_t             tag_q [ALU_LATENCY];
    tag_t             tag_d [ALU_LATENCY];

    logic [NUM_REQ-1:0] gnt_s;
    logic [IDX_W-1:0]   win_s;
    logic               issue_s;
    logic               arb_en_s;
    tag_t               tail_s;
    logic               chk_en_s;
    logic               ret_ok_s;

    // The ALU has no reset, so nothing is issued or trusted until its pipe has drained.
    assign arb_en_s = (drain_q == '0);

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .en_i    (arb_en_s),
        .gnt_o   (gnt_s),
        .idx_o   (win_s),
        .found_o (issue_s)
    );

    assign req_ready_o = gnt_s;
    assign alu_valid_o = issue_s;
    assign resp_data_o = alu_data_i;
    assign inflight_o  = inflight_q;
    assign err_o       = err_q;

    // Operand mux: the one-hot grant selects the winner's fields, all-zero when idle
    always_comb begin
        alu_data1_o = '0;
        alu_data2_o = '0;
        alu_sel_o   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            alu_data1_o = alu_data1_o | ({DATA_WIDTH{gnt_s[k]}} & req_data1_i[k*DATA_WIDTH +: DATA_WIDTH]);
            alu_data2_o = alu_data2_o | ({DATA_WIDTH{gnt_s[k]}} & req_data2_i[k*DATA_WIDTH +: DATA_WIDTH]);
            alu_sel_o   = alu_sel_o   | ({SEL_WIDTH{gnt_s[k]}}  & req_sel_i[k*SEL_WIDTH +: SEL_WIDTH]);
        end
    end

    // Return path: match ALU valid against the tag pipe tail and steer the strobe
    always_comb begin
        tail_s       = tag_q[ALU_LATENCY-1];
        chk_en_s     = (drain_q == '0);
        ret_ok_s     = chk_en_s & alu_valid_i & tail_s.v;
        resp_valid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            resp_valid_o[k] = ret_ok_s & (tail_s.id == TAG_ID_W'(k));
        end
    end

    // Next-state for pointer, drain, occupancy, sticky error and tag pipe
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue_s) begin
            rr_ptr_d = (win_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_s + IDX_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        drain_d = (drain_q != '0) ? drain_q - CNT_W'(1) : drain_q;

        // A valid/tag disagreement means the ALU and our bookkeeping have diverged.
        err_d = err_q | (chk_en_s & (alu_valid_i != tail_s.v));

        case ({issue_s, ret_ok_s})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        tag_d[0].v  = issue_s;
        tag_d[0].id = TAG_ID_W'(win_s);
        for (int i = 1; i < ALU_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            drain_q    <= CNT_W'(ALU_LATENCY);
            inflight_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < ALU_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            drain_q    <= drain_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            for (int i = 0; i < ALU_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter with a behavioural 2-cycle ALU, directed scenarios and a
// randomized run scored against a queue-based reference model.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NR-1:0]      req_valid_i = '0;
    logic [NR*DW-1:0]   req_data1_i = '0;
    logic [NR*DW-1:0]   req_data2_i = '0;
    logic [NR*SW-1:0]   req_sel_i = '0;
    logic [NR-1:0]      req_ready_o;
    logic               alu_valid_o;
    logic [DW-1:0]      alu_data1_o;
    logic [DW-1:0]      alu_data2_o;
    logic [SW-1:0]      alu_sel_o;
    logic               alu_valid_i;
    logic [2*DW-1:0]    alu_data_i;
    logic [NR-1:0]      resp_valid_o;
    logic [2*DW-1:0]    resp_data_o;
    logic [1:0]         inflight_o;
    logic               err_o;

    logic               spur = 1'b0;
    logic               alu_v1 = 1'b0;
    logic               alu_v2 = 1'b0;
    logic [2*DW-1:0]    alu_r1 = '0;
    logic [2*DW-1:0]    alu_r2 = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          id;
        logic [15:0] res;
        int          due;
    } exp_t;

    always #5 clk = ~clk;

    alu_req_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .SEL_WIDTH   (SW),
        .ALU_LATENCY (ALU_LATENCY)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_data1_i  (req_data1_i),
        .req_data2_i  (req_data2_i),
        .req_sel_i    (req_sel_i),
        .alu_valid_o  (alu_valid_o),
        .alu_data1_o  (alu_data1_o),
        .alu_data2_o  (alu_data2_o),
        .alu_sel_o    (alu_sel_o),
        .alu_valid_i  (alu_valid_i),
        .alu_data_i   (alu_data_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .inflight_o   (inflight_o),
        .err_o        (err_o)
    );

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        case (s)
            ALU_OP_ADD: return 16'(a) + 16'(b);
            ALU_OP_SUB: return 16'(a) - 16'(b);
            ALU_OP_INC: return 16'(a) + 16'd1;
            default:    return 16'd0;
        endcase
    endfunction

    // Behavioural ALU: two register stages, no reset, no backpressure
    always @(posedge clk) begin
        alu_v1 <= alu_valid_o;
        alu_r1 <= alu_ref(alu_data1_o, alu_data2_o, alu_sel_o);
        alu_v2 <= alu_v1;
        alu_r2 <= alu_r1;
    end
    assign alu_valid_i = alu_v2 | spur;
    assign alu_data_i  = alu_r2;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        req_valid_i[k]          = v;
        req_data1_i[k*DW +: DW] = a;
        req_data2_i[k*DW +: DW] = b;
        req_sel_i[k*SW +: SW]   = s;
    endtask

    // Leaves the bench in the first cycle after release (drain still full)
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        req_valid_i = '0;
        spur        = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 8'(k + 1), 8'd1, ALU_OP_ADD);
        @(negedge clk);
        tests++;
        if ({req_ready_o, alu_valid_o, resp_valid_o, inflight_o, err_o} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b valid=%b resp=%b infl=%0d err=%b expected all 0",
                     req_ready_o, alu_valid_o, resp_valid_o, inflight_o, err_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if ({req_ready_o, inflight_o, err_o} !== 7'h00) begin
                fails++;
                $display("FAIL drain_cycle%0d: ready=%b infl=%0d err=%b expected 0000/0/0",
                         c + 1, req_ready_o, inflight_o, err_o);
            end
            next_cycle();
        end
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0001 || alu_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL first_grant: ready=%b valid=%b expected 0001/1", req_ready_o, alu_valid_o);
        end
        next_cycle();
        req_valid_i = '0;
        repeat (3) next_cycle();
    endtask

    task automatic test_single();
        set_req(2, 1'b1, 8'd10, 8'd5, ALU_OP_ADD);
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0100 || alu_data1_o !== 8'd10 || alu_data2_o !== 8'd5 || alu_sel_o !== 2'b00) begin
            fails++;
            $display("FAIL single_issue: ready=%b d1=%0d d2=%0d sel=%b expected 0100/10/5/00",
                     req_ready_o, alu_data1_o, alu_data2_o, alu_sel_o);
        end
        next_cycle();
        req_valid_i = '0;
        @(negedge clk);
        tests++;
        if (resp_valid_o !== 4'b0000 || inflight_o !== 2'd1) begin
            fails++;
            $display("FAIL single_wait: resp=%b infl=%0d expected 0000/1", resp_valid_o, inflight_o);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (resp_valid_o !== 4'b0100 || resp_data_o !== 16'd15) begin
            fails++;
            $display("FAIL single_resp: resp=%b data=%h expected 0100/000f", resp_valid_o, resp_data_o);
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_all_valid();
        logic [3:0]  exp_g;
        logic [3:0]  exp_r;
        logic [15:0] exp_d;
        logic [1:0]  exp_i;
        do_reset();
        repeat (2) next_cycle();
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 8'(k + 1), 8'd1, ALU_OP_ADD);
        for (int i = 0; i < 10; i++) begin
            exp_g = 4'(1 << (i % 4));
            exp_r = (i >= 2) ? 4'(1 << ((i - 2) % 4)) : 4'b0000;
            exp_d = 16'(((i - 2) % 4) + 2);
            exp_i = (i < 2) ? 2'(i) : 2'd2;
            @(negedge clk);
            tests++;
            if (req_ready_o !== exp_g) begin
                fails++;
                $display("FAIL rotate_grant[%0d]: ready=%b expected %b", i, req_ready_o, exp_g);
            end
            tests++;
            if (resp_valid_o !== exp_r || (i >= 2 && resp_data_o !== exp_d) || inflight_o !== exp_i) begin
                fails++;
                $display("FAIL rotate_resp[%0d]: resp=%b data=%h infl=%0d expected %b/%h/%0d",
                         i, resp_valid_o, resp_data_o, inflight_o, exp_r, exp_d, exp_i);
            end
            next_cycle();
        end
        req_valid_i = '0;
        repeat (3) next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (2) next_cycle();
        set_req(1, 1'b1, 8'd3, 8'd5, ALU_OP_SUB);
        set_req(3, 1'b1, 8'hFF, 8'd1, ALU_OP_INC);
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0010) begin
            fails++;
            $display("FAIL b2b_grant1: ready=%b expected 0010", req_ready_o);
        end
        next_cycle();
        req_valid_i[1] = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b1000) begin
            fails++;
            $display("FAIL b2b_grant3: ready=%b expected 1000", req_ready_o);
        end
        next_cycle();
        req_valid_i[3] = 1'b0;
        @(negedge clk);
        tests++;
        if (resp_valid_o !== 4'b0010 || resp_data_o !== 16'hFFFE) begin
            fails++;
            $display("FAIL b2b_resp1: resp=%b data=%h expected 0010/fffe", resp_valid_o, resp_data_o);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (resp_valid_o !== 4'b1000 || resp_data_o !== 16'h0100) begin
            fails++;
            $display("FAIL b2b_resp3: resp=%b data=%h expected 1000/0100", resp_valid_o, resp_data_o);
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_spurious();
        spur = 1'b1;
        @(negedge clk);
        tests++;
        if (resp_valid_o !== 4'b0000 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL spur_cycle: resp=%b err=%b expected 0000/0", resp_valid_o, err_o);
        end
        next_cycle();
        spur = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (err_o !== 1'b1 || resp_valid_o !== 4'b0000) begin
                fails++;
                $display("FAIL spur_sticky[%0d]: err=%b resp=%b expected 1/0000", c, err_o, resp_valid_o);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (2) next_cycle();
        set_req(0, 1'b1, 8'd5, 8'd6, ALU_OP_ADD);
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0001) begin
            fails++;
            $display("FAIL mid_issue: ready=%b expected 0001", req_ready_o);
        end
        next_cycle();
        req_valid_i = '0;
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (resp_valid_o !== 4'b0000 || inflight_o !== 2'd0) begin
            fails++;
            $display("FAIL mid_in_reset: resp=%b infl=%0d expected 0000/0", resp_valid_o, inflight_o);
        end
        next_cycle();
        rst_n = 1'b1;
        set_req(2, 1'b1, 8'd7, 8'd7, ALU_OP_ADD);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if (resp_valid_o !== 4'b0000 || req_ready_o !== 4'b0000 || err_o !== 1'b0) begin
                fails++;
                $display("FAIL mid_drain[%0d]: resp=%b ready=%b err=%b expected 0000/0000/0",
                         c, resp_valid_o, req_ready_o, err_o);
            end
            next_cycle();
        end
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0100) begin
            fails++;
            $display("FAIL mid_resume: ready=%b expected 0100", req_ready_o);
        end
        next_cycle();
        req_valid_i = '0;
        next_cycle();
        @(negedge clk);
        tests++;
        if (resp_valid_o !== 4'b0100 || resp_data_o !== 16'd14 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_resp: resp=%b data=%h err=%b expected 0100/000e/0", resp_valid_o, resp_data_o, err_o);
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_random();
        exp_t        sb[$];
        exp_t        e;
        int          ptr;
        int          drain;
        int          cyc;
        int          w;
        int          k;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_resp;
        logic [15:0] exp_data;
        do_reset();
        ptr   = 0;
        drain = ALU_LATENCY;
        cyc   = 0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid_i[r] && $urandom_range(0, 1) == 1)
                    set_req(r, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
            end
            w = -1;
            if (drain == 0) begin
                for (int off = 0; off < NR; off++) begin
                    k = (ptr + off) % NR;
                    if (w < 0 && req_valid_i[k]) w = k;
                end
            end
            exp_rdy  = (w < 0) ? 4'b0000 : 4'(1 << w);
            exp_resp = 4'b0000;
            exp_data = 16'h0000;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_resp = 4'(1 << sb[0].id);
                exp_data = sb[0].res;
            end
            @(negedge clk);
            tests++;
            if (req_ready_o !== exp_rdy || alu_valid_o !== (w >= 0)) begin
                fails++;
                $display("FAIL rnd_grant@%0d: ready=%b valid=%b expected %b", cyc, req_ready_o, alu_valid_o, exp_rdy);
            end
            if (w >= 0) begin
                tests++;
                if (alu_data1_o !== req_data1_i[w*DW +: DW] || alu_data2_o !== req_data2_i[w*DW +: DW] ||
                    alu_sel_o !== req_sel_i[w*SW +: SW]) begin
                    fails++;
                    $display("FAIL rnd_operands@%0d: d1=%h d2=%h sel=%b expected %h/%h/%b", cyc,
                             alu_data1_o, alu_data2_o, alu_sel_o, req_data1_i[w*DW +: DW],
                             req_data2_i[w*DW +: DW], req_sel_i[w*SW +: SW]);
                end
            end
            tests++;
            if (resp_valid_o !== exp_resp || (exp_resp != 4'b0000 && resp_data_o !== exp_data)) begin
                fails++;
                $display("FAIL rnd_resp@%0d: resp=%b data=%h expected %b/%h", cyc, resp_valid_o, resp_data_o, exp_resp, exp_data);
            end
            tests++;
            if (inflight_o !== 2'(sb.size()) || err_o !== 1'b0) begin
                fails++;
                $display("FAIL rnd_state@%0d: infl=%0d err=%b expected %0d/0", cyc, inflight_o, err_o, sb.size());
            end
            if (exp_resp != 4'b0000) void'(sb.pop_front());
            if (w >= 0) begin
                e.id  = w;
                e.res = alu_ref(req_data1_i[w*DW +: DW], req_data2_i[w*DW +: DW], req_sel_i[w*SW +: SW]);
                e.due = cyc + ALU_LATENCY;
                sb.push_back(e);
                ptr = (w + 1) % NR;
            end
            if (drain > 0) drain--;
            next_cycle();
            if (w >= 0) req_valid_i[w] = 1'b0;
            cyc++;
        end
        req_valid_i = '0;
        repeat (3) next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
